// File: rtl/rr_arbiter_4x1.sv
// Round-robin arbiter for four requesters sharing one 4:1 mux.
// Grants are held until the owner drops its request or the hold limit expires.
module rr_arbiter_4x1 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       expired
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state_reg, state_next;
  logic [3:0] gnt_reg, gnt_next;
  logic [1:0] sel_reg, sel_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [7:0] hcnt_reg, hcnt_next;
  logic       expired_reg, expired_next;

  logic [3:0] rot_req;
  logic [1:0] pick_off;
  logic [1:0] pick_idx;
  logic       pick_valid;
  logic       owner_req;
  logic       hold_hit;
  logic       release_grant;
  logic       do_grant;

  // Requests rotated so that bit 0 is the requester at the round-robin pointer.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_req[gi] = req[ptr_reg + 2'(gi)];
  end

  always_comb begin
    pick_off = 2'd0;
    if (rot_req[0])      pick_off = 2'd0;
    else if (rot_req[1]) pick_off = 2'd1;
    else if (rot_req[2]) pick_off = 2'd2;
    else                 pick_off = 2'd3;
  end

  assign pick_valid    = |req;
  assign pick_idx      = ptr_reg + pick_off;
  assign owner_req     = req[sel_reg];
  assign hold_hit      = HOLD_EN && (hcnt_reg == HOLD_LAST);
  assign release_grant = !owner_req || hold_hit;

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    sel_next     = sel_reg;
    ptr_next     = ptr_reg;
    hcnt_next    = hcnt_reg;
    expired_next = 1'b0;
    do_grant     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_valid) do_grant = 1'b1;
      end
      GRANT: begin
        if (!release_grant) begin
          hcnt_next = (hcnt_reg == 8'hFF) ? hcnt_reg : hcnt_reg + 8'd1;
        end else begin
          // Only a limit-forced release while the owner still wants the bus counts.
          expired_next = hold_hit && owner_req;
          if (pick_valid) begin
            do_grant = 1'b1;
          end else begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (do_grant) begin
      state_next = GRANT;
      gnt_next   = 4'b0001 << pick_idx;
      sel_next   = pick_idx;
      ptr_next   = pick_idx + 2'd1;
      hcnt_next  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gnt_reg     <= 4'b0000;
      sel_reg     <= 2'd0;
      ptr_reg     <= 2'd0;
      hcnt_reg    <= 8'd0;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      sel_reg     <= sel_next;
      ptr_reg     <= ptr_next;
      hcnt_reg    <= hcnt_next;
      expired_reg <= expired_next;
    end
  end

  assign gnt     = gnt_reg;
  assign sel     = sel_reg;
  assign busy    = |gnt_reg;
  assign expired = expired_reg;

endmodule

// File: tb/tb_rr_arbiter_4x1.sv
// Drives three arbiters (hold limits 4, 3 and unlimited) with directed and random
// request patterns and compares every cycle against a behavioural model.
module tb_rr_arbiter_4x1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [2:0][3:0] gnt_v;
  logic [2:0][1:0] sel_v;
  logic [2:0]      busy_v;
  logic [2:0]      exp_v;

  int errors = 0;
  int checks = 0;

  localparam int MH [3] = '{4, 3, 0};

  // Model state: owner index (-1 when idle), search start, grant cycles so far.
  int m_owner [3];
  int m_ptr   [3];
  int m_held  [3];
  int m_last  [3];
  bit m_exp   [3];

  always #5 clk = ~clk;

  rr_arbiter_4x1 #(.MAX_HOLD(4)) dut_h4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_v[0]), .sel(sel_v[0]), .busy(busy_v[0]), .expired(exp_v[0])
  );
  rr_arbiter_4x1 #(.MAX_HOLD(3)) dut_h3 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_v[1]), .sel(sel_v[1]), .busy(busy_v[1]), .expired(exp_v[1])
  );
  rr_arbiter_4x1 #(.MAX_HOLD(0)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_v[2]), .sel(sel_v[2]), .busy(busy_v[2]), .expired(exp_v[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int rr_search(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = -1;
      m_ptr[i]   = 0;
      m_held[i]  = 0;
      m_last[i]  = 0;
      m_exp[i]   = 1'b0;
    end
  endtask

  task automatic model_grant(input int i, input int w);
    m_owner[i] = w;
    m_last[i]  = w;
    m_ptr[i]   = (w + 1) % 4;
    m_held[i]  = 1;
  endtask

  task automatic model_step();
    int w;
    bit hit;
    for (int i = 0; i < 3; i++) begin
      m_exp[i] = 1'b0;
      w = rr_search(m_ptr[i], req);
      if (m_owner[i] < 0) begin
        if (w >= 0) model_grant(i, w);
      end else begin
        hit = (MH[i] != 0) && (m_held[i] == MH[i]);
        if (req[m_owner[i]] && !hit) begin
          m_held[i]++;
        end else begin
          m_exp[i] = hit && req[m_owner[i]];
          if (w >= 0) model_grant(i, w);
          else        m_owner[i] = -1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("gnt%0d", i),  32'(gnt_v[i]),
               (m_owner[i] < 0) ? 32'd0 : (32'd1 << m_owner[i]));
      check_eq($sformatf("sel%0d", i),  32'(sel_v[i]),  32'(m_last[i]));
      check_eq($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(m_owner[i] >= 0));
      check_eq($sformatf("exp%0d", i),  32'(exp_v[i]),  32'(m_exp[i]));
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_gnt%0d", i), 32'(gnt_v[i]), 32'd0);
      check_eq($sformatf("rst_sel%0d", i), 32'(sel_v[i]), 32'd0);
    end
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Simultaneous start; each owner drops right after its grant.
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step_cycle();
      check_eq($sformatf("order%0d", k), 32'(gnt_v[0]), 32'd1 << k);
      req[k] = 1'b0;
    end
    step_cycle();
    check_eq("idle_sel", 32'(sel_v[0]), 32'd3);
    check_eq("idle_busy", 32'(busy_v[0]), 32'd0);
    req = 4'b1001;
    step_cycle();
    check_eq("wrap_gnt", 32'(gnt_v[0]), 32'b0001);
    req = 4'b0000;
    step_cycle();

    // Fairness between two persistent requesters.
    req = 4'b1010;
    repeat (24) step_cycle();
    req = 4'b0000;
    step_cycle();

    // Sole requester keeps being re-granted on expiry.
    req = 4'b0100;
    repeat (12) step_cycle();
    check_eq("sole_sel", 32'(sel_v[1]), 32'd2);

    // Long hold; unlimited instance never lets go.
    req = 4'b0011;
    repeat (300) step_cycle();
    check_eq("unlim_hold", 32'(gnt_v[2]), 32'b0001);
    req = 4'b0010;
    step_cycle();
    check_eq("unlim_drop", 32'(gnt_v[2]), 32'b0010);

    // Reset in the middle of a grant to requester 2.
    req = 4'b0000;
    step_cycle();
    req = 4'b0100;
    repeat (2) step_cycle();
    pulse_reset();
    req = 4'b0001;
    step_cycle();
    check_eq("post_rst_gnt", 32'(gnt_v[0]), 32'b0001);

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      step_cycle();
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
